// File: rtl/any1_bitfield_pipe.sv
// Two-stage pipelined ANY-1 bitfield unit: SET/CLR/CHG/INS/EXT/EXTU/FFO with valid/ready and tag.
// Optional: define ANY1_BITFIELD_FFO_EN to build the FFO priority encoder; otherwise op 6 traps like op 7.
module any1_bitfield_pipe #(
  parameter int DWIDTH = 64,
  parameter int TAGW   = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        op_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic [DWIDTH-1:0] c_i,
  input  logic [DWIDTH-1:0] d_i,
  input  logic [TAGW-1:0]   tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] o_o,
  output logic [DWIDTH-1:0] masko_o,
  output logic [TAGW-1:0]   tag_o,
  output logic              exc_o
);

  localparam int LW = $clog2(DWIDTH);

  logic [LW-1:0]       mb, mw, me;
  logic [DWIDTH-1:0]   mask;
  logic [2*DWIDTH-1:0] rot_wide, ext_wide;

  logic                s1_valid, s2_valid, s1_adv, s2_adv;
  logic [2:0]          s1_op;
  logic [TAGW-1:0]     s1_tag;
  logic [DWIDTH-1:0]   s1_mask, s1_a, s1_rot, s1_ext;
  logic [LW-1:0]       s1_mb, s1_mw;

  logic [DWIDTH-1:0]   res, res_mask;
  logic                res_exc;

  assign mb = c_i[LW-1:0];
  assign mw = d_i[LW-1:0];
  assign me = mb + mw;

  // Three-way XOR yields either the contiguous field mb..me or its wrapped form.
  always_comb begin
    mask = '0;
    for (int n = 0; n < DWIDTH; n++)
      mask[n] = ((LW'(n) >= mb) ^ (LW'(n) <= me)) ^ (me >= mb);
  end

  assign rot_wide = {b_i, b_i} << mb;
  assign ext_wide = {b_i, a_i} >> mb;

  assign s2_adv      = !s2_valid || out_ready_i;
  assign s1_adv      = !s1_valid || s2_adv;
  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_mask  <= '0;
      s1_a     <= '0;
      s1_rot   <= '0;
      s1_ext   <= '0;
      s1_mb    <= '0;
      s1_mw    <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_op   <= op_i;
        s1_tag  <= tag_i;
        s1_mask <= mask;
        s1_a    <= a_i;
        s1_rot  <= rot_wide[2*DWIDTH-1:DWIDTH];
        s1_ext  <= ext_wide[DWIDTH-1:0];
        s1_mb   <= mb;
        s1_mw   <= mw;
      end
    end
  end

`ifdef ANY1_BITFIELD_FFO_EN
  logic [DWIDTH-1:0] ffo_bits, ffo_res;
  logic [LW-1:0]     ffo_pos;
  logic              ffo_hit;

  // Ascending scan: the last hit wins, giving the most-significant set bit.
  always_comb begin
    ffo_bits = s1_a & s1_mask;
    ffo_pos  = '0;
    ffo_hit  = 1'b0;
    for (int n = 0; n < DWIDTH; n++) begin
      if (ffo_bits[n]) begin
        ffo_pos = LW'(n);
        ffo_hit = 1'b1;
      end
    end
    ffo_res = ffo_hit ? (DWIDTH'(ffo_pos) - DWIDTH'(s1_mb)) : '1;
  end
`endif

  always_comb begin
    res      = '0;
    res_mask = s1_mask;
    res_exc  = 1'b0;
    case (s1_op)
      3'd0: res = s1_a | s1_mask;
      3'd1: res = s1_a & ~s1_mask;
      3'd2: res = s1_a ^ s1_mask;
      3'd3: res = (s1_rot & s1_mask) | (s1_a & ~s1_mask);
      3'd4, 3'd5: begin
        for (int n = 0; n < DWIDTH; n++) begin
          if (LW'(n) <= s1_mw)
            res[n] = s1_ext[n];
          else
            res[n] = (s1_op == 3'd4) ? s1_ext[s1_mw] : 1'b0;
        end
      end
      3'd6: begin
`ifdef ANY1_BITFIELD_FFO_EN
        res = ffo_res;
`else
        res_mask = '0;
        res_exc  = 1'b1;
`endif
      end
      default: begin
        res_mask = '0;
        res_exc  = 1'b1;
      end
    endcase
  end

  // Outputs only load on a real hand-off, so they hold while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      o_o      <= '0;
      masko_o  <= '0;
      tag_o    <= '0;
      exc_o    <= 1'b0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_o     <= res;
        masko_o <= res_mask;
        tag_o   <= s1_tag;
        exc_o   <= res_exc;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{c_i[DWIDTH-1:LW], d_i[DWIDTH-1:LW], s1_mb,
                         rot_wide[DWIDTH-1:0], ext_wide[2*DWIDTH-1:DWIDTH]};

endmodule

// File: doc/any1_bitfield_pipe.md
Name: any1_bitfield_pipe

Overview:
Parametrised, two-stage pipelined bitfield unit for the ANY-1 execute path. It implements SET/CLR/CHG/INS/EXT/EXTU/FFO over a DWIDTH-bit operand. It generalises the combinational bitfield unit with a configurable width, wrap-around fields, rotate-insert and masked FFO. Valid/ready handshakes and a tag let it sit between issue and writeback with back-pressure.

Parameters:
DWIDTH, 64, operand width; power of two, 16..128.
LW, $clog2(DWIDTH), width of field-begin and field-width codes (derived, not overridden).
TAGW, 6, width of pass-through destination tag.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  sync flush: drop all in-flight ops
in_valid_i  in  1  request valid
in_ready_o  out  1  unit can accept request this cycle
op_i  in  3  0 SET, 1 CLR, 2 CHG, 3 INS, 4 EXT, 5 EXTU, 6 FFO, 7 reserved
a_i  in  DWIDTH  target/source operand
b_i  in  DWIDTH  insert value (INS); upper half of {b,a} (EXT/EXTU)
c_i  in  DWIDTH  field begin mb = c_i[LW-1:0]
d_i  in  DWIDTH  field width-1 mw = d_i[LW-1:0]
tag_i  in  TAGW  tag carried with op
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
o_o  out  DWIDTH  result
masko_o  out  DWIDTH  field mask used
tag_o  out  TAGW  tag of result
exc_o  out  1  illegal op flag, qualified by out_valid_o

Behaviour:
- Reset (rst_ni low, async): s1_valid=0, s2_valid=0, out_valid_o=0, o_o=0, masko_o=0, tag_o=0, exc_o=0. Reset mid-operation discards in-flight ops silently.
- Transfer on in_valid_i&in_ready_o (accept) and out_valid_o&out_ready_i (retire).
- Pipeline: S1 registers mask, rotated/shifted operands, op, tag. S2 registers final result. Latency is 2 cycles from accept to out_valid_o. Throughput is 1 op/cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready_i.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready_o = s1_adv, combinational from out_ready_i; no path from in_valid_i.
- Full: both stages valid with out_ready_i=0 gives in_ready_o=0. Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous accept and retire with both stages full: all stages shift; no bubble, no loss.
- flush_i: clears s1_valid and s2_valid next edge. Any accept in the same cycle is dropped. Flush wins over everything except reset.
- Field arithmetic:
  - me = (mb+mw) mod DWIDTH.
  - mask[n] = (n>=mb) ^ (n<=me) ^ (me>=mb). This gives contiguous bits mb..me, or wraps to bits >=mb plus bits <=me when mb+mw >= DWIDTH.
  - Field length is mw+1; mw = DWIDTH-1 selects all bits.
- Ops:
  - SET: o = a | mask.
  - CLR: o = a & ~mask.
  - CHG: o = a ^ mask.
  - INS: o = (rotl(b,mb) & mask) | (a & ~mask).
  - EXTU: t = ({b,a} >> mb)[DWIDTH-1:0]; o[n] = n<=mw ? t[n] : 0.
  - EXT: as EXTU but o[n] = t[mw] for n>mw.
  - FFO: p = index of most-significant 1 in (a & mask). o = (p - mb) mod 2^DWIDTH. If a&mask has no 1, o = all ones.
- masko_o is the mask for every op, including EXT/EXTU.
- op 7: o=0, masko_o=0, exc_o=1; the op still occupies the pipeline and retires in order.

Optional Feature:
ANY1_BITFIELD_FFO_EN.
- Defined: FFO implemented as above.
- Undefined: priority encoder not built. op 6 behaves as op 7 (o=0, masko_o=0, exc_o=1). All other timing is unchanged.

Test Plan:
DWIDTH=64, out_ready_i=1 unless noted.
- SET a=0, mb=4, mw=3: accept at cycle T -> out_valid_o at T+2; o=0x00000000000000F0, masko=0xF0, exc=0, tag echoed.
- EXT a=0xA50, mb=4, mw=7 -> o=0xFFFFFFFFFFFFFFA5. Same with EXTU -> o=0xA5.
- Wrap: CLR a=all ones, mb=62, mw=3 -> o=0x3FFFFFFFFFFFFFFC, masko=0xC000000000000003. INS a=0, b=0xF, same field -> o=0xC000000000000003.
- FFO a=0x10100, mb=4, mw=11 -> o=4. FFO with mb=20, mw=3 -> o=0xFFFFFFFFFFFFFFFF. Without ANY1_BITFIELD_FFO_EN -> o=0, exc=1.
- Back-pressure: out_ready_i=0, present 3 back-to-back ops tagged 1,2,3. Tags 1 and 2 are accepted, then in_ready_o=0 and tag 3 is held. Raise out_ready_i: results retire in order 1,2,3; outputs stable during the stall.
- Disruptions:
  - flush_i with 2 ops in flight -> no out_valid_o for those ops.
  - rst_ni pulsed low mid-pipe -> all outputs 0 immediately (async); next accepted op retires normally 2 cycles later.
